// File: rtl/inert_spi_resp.sv
// SPI slave register block: synchronized SPI pins, small cfg register file and a
// sample holding pair with data-ready interrupt, read lock and overrun flag.
module inert_spi_resp #(
    parameter logic [7:0] WHOAMI = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl_vld,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] AZ_in,
    output logic [7:0]  cfg_int1,
    output logic [7:0]  cfg_xl,
    output logic [7:0]  cfg_g,
    output logic [7:0]  cfg_ctrl5,
    output logic        overrun
);

    logic        ss_ff1, ss_ff2, ss_ff3;
    logic        sclk_ff1, sclk_ff2, sclk_ff3;
    logic        mosi_ff1, mosi_ff2, mosi_ff3;
    logic [4:0]  bit_cnt;
    logic [15:0] rx;
    logic [7:0]  tx;
    logic [15:0] ptch_hold;
    logic [15:0] az_hold;
    logic        lock;

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        frame_done, rd_done_22, rd_done_2d, smpl_take, int_set;
    logic [7:0]  cmd;
    logic [7:0]  rd_data;

    assign ss_fall   = ss_ff3 & ~ss_ff2;
    assign ss_rise   = ~ss_ff3 & ss_ff2;
    assign sclk_rise = ~ss_ff2 & ~sclk_ff3 & sclk_ff2;
    assign sclk_fall = ~ss_ff2 & sclk_ff3 & ~sclk_ff2;

    // Command byte as it will look once the 8th bit is shifted in.
    assign cmd = {rx[6:0], mosi_ff3};

    assign frame_done = ss_rise && (bit_cnt == 5'd16);
    assign rd_done_22 = frame_done && rx[15] && (rx[14:8] == 7'h22);
    assign rd_done_2d = frame_done && rx[15] && (rx[14:8] == 7'h2D);
    assign smpl_take  = smpl_vld && !lock;
    assign int_set    = smpl_take && cfg_int1[1];

    assign MISO = tx[7];

    always_comb begin
        rd_data = 8'h00;
        case (cmd[6:0])
            7'h0D:   rd_data = cfg_int1;
            7'h0F:   rd_data = WHOAMI;
            7'h10:   rd_data = cfg_xl;
            7'h11:   rd_data = cfg_g;
            7'h14:   rd_data = cfg_ctrl5;
            7'h22:   rd_data = ptch_hold[7:0];
            7'h23:   rd_data = ptch_hold[15:8];
            7'h2C:   rd_data = az_hold[7:0];
            7'h2D:   rd_data = az_hold[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_ff1    <= 1'b1;
            ss_ff2    <= 1'b1;
            ss_ff3    <= 1'b1;
            sclk_ff1  <= 1'b1;
            sclk_ff2  <= 1'b1;
            sclk_ff3  <= 1'b1;
            mosi_ff1  <= 1'b0;
            mosi_ff2  <= 1'b0;
            mosi_ff3  <= 1'b0;
            bit_cnt   <= 5'd0;
            rx        <= 16'h0000;
            tx        <= 8'h00;
            cfg_int1  <= 8'h00;
            cfg_xl    <= 8'h00;
            cfg_g     <= 8'h00;
            cfg_ctrl5 <= 8'h00;
            ptch_hold <= 16'h0000;
            az_hold   <= 16'h0000;
            lock      <= 1'b0;
            overrun   <= 1'b0;
            INT       <= 1'b0;
        end else begin
            ss_ff1   <= SS_n;
            ss_ff2   <= ss_ff1;
            ss_ff3   <= ss_ff2;
            sclk_ff1 <= SCLK;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            mosi_ff1 <= MOSI;
            mosi_ff2 <= mosi_ff1;
            mosi_ff3 <= mosi_ff2;

            if (ss_fall) begin
                bit_cnt <= 5'd0;
                rx      <= 16'h0000;
                tx      <= 8'h00;
            end else if (sclk_rise) begin
                rx <= {rx[14:0], mosi_ff3};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (bit_cnt == 5'd7 && cmd[7]) begin
                    tx <= rd_data;
                end
            end else if (sclk_fall && bit_cnt >= 5'd9) begin
                tx <= {tx[6:0], 1'b0};
            end

            // Only a clean 16-bit write frame touches the cfg registers.
            if (frame_done && !rx[15]) begin
                case (rx[14:8])
                    7'h0D:   cfg_int1  <= rx[7:0];
                    7'h10:   cfg_xl    <= rx[7:0];
                    7'h11:   cfg_g     <= rx[7:0];
                    7'h14:   cfg_ctrl5 <= rx[7:0];
                    default: ;
                endcase
            end

            if (smpl_take) begin
                ptch_hold <= ptch_rt_in;
                az_hold   <= AZ_in;
            end else if (smpl_vld) begin
                overrun <= 1'b1;
            end

            if (rd_done_22) begin
                lock <= 1'b1;
            end else if (rd_done_2d) begin
                lock <= 1'b0;
            end

            // Disabled interrupt dominates; a new sample beats a concurrent clear.
            if (!cfg_int1[1]) begin
                INT <= 1'b0;
            end else if (int_set) begin
                INT <= 1'b1;
            end else if (rd_done_22) begin
                INT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: directed frames plus randomized traffic checked against
// a transaction-level model of the register map, sample lock and interrupt.
module tb_inert_spi_resp;

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI, smpl_vld;
    logic [15:0] ptch_rt_in, AZ_in;
    logic        MISO, INT, overrun;
    logic [7:0]  cfg_int1, cfg_xl, cfg_g, cfg_ctrl5;

    inert_spi_resp #(.WHOAMI(8'h6A)) dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .INT        (INT),
        .smpl_vld   (smpl_vld),
        .ptch_rt_in (ptch_rt_in),
        .AZ_in      (AZ_in),
        .cfg_int1   (cfg_int1),
        .cfg_xl     (cfg_xl),
        .cfg_g      (cfg_g),
        .cfg_ctrl5  (cfg_ctrl5),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    localparam int Half = 6;

    int n_chk  = 0;
    int n_pass = 0;
    bit settled = 1'b0;

    logic [7:0]  m_int1, m_xl, m_g, m_ctrl5;
    logic [15:0] m_ptch, m_az;
    logic        m_int, m_lock, m_ovr;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (settled && !rst) begin
            chk("outputs", {6'b0, cfg_int1, cfg_xl, cfg_g, cfg_ctrl5, INT, overrun},
                {6'b0, m_int1, m_xl, m_g, m_ctrl5, m_int, m_ovr});
        end
    end

    function automatic logic [7:0] m_read(input logic [6:0] a);
        case (a)
            7'h0D:   return m_int1;
            7'h0F:   return 8'h6A;
            7'h10:   return m_xl;
            7'h11:   return m_g;
            7'h14:   return m_ctrl5;
            7'h22:   return m_ptch[7:0];
            7'h23:   return m_ptch[15:8];
            7'h2C:   return m_az[7:0];
            7'h2D:   return m_az[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        {m_int1, m_xl, m_g, m_ctrl5} = '0;
        m_ptch = '0;
        m_az   = '0;
        m_int  = 1'b0;
        m_lock = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic m_frame(input logic [15:0] w, input int nclk);
        if (nclk == 16) begin
            if (!w[15]) begin
                case (w[14:8])
                    7'h0D: begin
                        m_int1 = w[7:0];
                        if (!w[1]) m_int = 1'b0;
                    end
                    7'h10: m_xl = w[7:0];
                    7'h11: m_g = w[7:0];
                    7'h14: m_ctrl5 = w[7:0];
                    default: ;
                endcase
            end else if (w[14:8] == 7'h22) begin
                m_int  = 1'b0;
                m_lock = 1'b1;
            end else if (w[14:8] == 7'h2D) begin
                m_lock = 1'b0;
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves SS_n low; the captured byte is what MISO showed on rises 9..16.
    task automatic spi_xfer(input logic [15:0] w, input int nclk, output logic [7:0] rb);
        settled = 1'b0;
        SS_n = 1'b0;
        wait_clks(8);
        rb = 8'h00;
        for (int i = 0; i < nclk; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? w[15-i] : 1'b0;
            wait_clks(Half);
            SCLK = 1'b1;
            if (i >= 8 && i < 16) rb = {rb[6:0], MISO};
            wait_clks(Half);
        end
    endtask

    task automatic frame(input logic [15:0] w, input int nclk, output logic [7:0] rb);
        spi_xfer(w, nclk, rb);
        SS_n = 1'b1;
        MOSI = 1'b0;
        m_frame(w, nclk);
        wait_clks(8);
        settled = 1'b1;
    endtask

    task automatic sample(input logic [15:0] p, input logic [15:0] a);
        settled = 1'b0;
        ptch_rt_in = p;
        AZ_in = a;
        smpl_vld = 1'b1;
        wait_clks(1);
        smpl_vld = 1'b0;
        if (!m_lock) begin
            m_ptch = p;
            m_az   = a;
            if (m_int1[1]) m_int = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        wait_clks(2);
        settled = 1'b1;
    endtask

    task automatic do_reset();
        settled = 1'b0;
        rst = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        smpl_vld = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        m_reset();
        wait_clks(2);
        chk("reset_outputs", {6'b0, cfg_int1, cfg_xl, cfg_g, cfg_ctrl5, INT, overrun, MISO},
            40'h0);
        settled = 1'b1;
    endtask

    logic [7:0] rb;
    logic [6:0] alist [9];

    initial begin
        ptch_rt_in = '0;
        AZ_in = '0;
        alist = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h22, 7'h23, 7'h2C, 7'h2D};
        do_reset();

        frame(16'h0D02, 16, rb);
        frame(16'h1053, 16, rb);
        frame(16'h1150, 16, rb);
        frame(16'h1460, 16, rb);
        chk("cfg_int1", {32'h0, cfg_int1}, 40'h02);
        chk("cfg_xl", {32'h0, cfg_xl}, 40'h53);
        chk("cfg_g", {32'h0, cfg_g}, 40'h50);
        chk("cfg_ctrl5", {32'h0, cfg_ctrl5}, 40'h60);

        sample(16'h1234, 16'hFE01);
        chk("int_after_sample", {39'h0, INT}, 40'h1);
        frame(16'hA200, 16, rb);
        chk("rd_0x22", {32'h0, rb}, 40'h34);
        chk("int_after_rd22", {39'h0, INT}, 40'h0);
        frame(16'hA300, 16, rb);
        chk("rd_0x23", {32'h0, rb}, 40'h12);
        sample(16'h5555, 16'h6666);
        chk("overrun_set", {39'h0, overrun}, 40'h1);
        chk("int_after_drop", {39'h0, INT}, 40'h0);
        frame(16'hAC00, 16, rb);
        chk("rd_0x2C", {32'h0, rb}, 40'h01);
        frame(16'hAD00, 16, rb);
        chk("rd_0x2D", {32'h0, rb}, 40'hFE);

        frame(16'h8F00, 16, rb);
        chk("rd_whoami", {32'h0, rb}, 40'h6A);
        frame(16'hB000, 16, rb);
        chk("rd_unmapped", {32'h0, rb}, 40'h00);

        frame(16'h1077, 12, rb);
        chk("short_frame", {32'h0, cfg_xl}, 40'h53);
        frame(16'h1177, 17, rb);
        chk("long_frame", {32'h0, cfg_g}, 40'h50);

        spi_xfer(16'h1099, 6, rb);
        do_reset();
        frame(16'h0D02, 16, rb);
        chk("post_reset_wr", {32'h0, cfg_int1}, 40'h02);

        for (int it = 0; it < 150; it++) begin
            int r;
            logic [6:0] a;
            logic [15:0] w;
            logic [7:0] exp_rb;
            int nclk;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                sample(16'($urandom), 16'($urandom));
            end else begin
                a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : alist[$urandom_range(0, 8)];
                w = {1'($urandom), a, 8'($urandom)};
                r = int'($urandom_range(0, 9));
                nclk = (r < 8) ? 16 : ((r == 8) ? 12 : 17);
                exp_rb = m_read(a);
                frame(w, nclk, rb);
                if (w[15] && nclk == 16) chk("rand_read", {32'h0, rb}, {32'h0, exp_rb});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inert_spi_resp.md
INERT_SPI_RESP -- requirements
Module: inert_spi_resp

Interface
REQ-001 The block SHALL have parameter WHOAMI, default 8'h6A, the value returned on a read of address 0x0F.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all flops SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port SS_n, input, 1 bit: active-low SPI frame select from the master.
REQ-005 The block SHALL have port SCLK, input, 1 bit: SPI clock, idle high, with MOSI sampled on rise and MISO changed on fall.
REQ-006 The block SHALL have port MOSI, input, 1 bit: serial command and data, MSB first.
REQ-007 The block SHALL have port MISO, output, 1 bit: serial read data, MSB first.
REQ-008 The block SHALL have port INT, output, 1 bit: data-ready interrupt to the master.
REQ-009 The block SHALL have port smpl_vld, input, 1 bit: 1-clk strobe indicating that a new sample is present on ptch_rt_in and AZ_in.
REQ-010 The block SHALL have ports ptch_rt_in and AZ_in, each input, 16 bits: sample data.
REQ-011 The block SHALL have ports cfg_int1, cfg_xl, cfg_g and cfg_ctrl5, each output, 8 bits: the register contents at addresses 0x0D, 0x10, 0x11 and 0x14.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a sample is dropped.

Function
REQ-013 SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer plus 1 edge-detect flop; SPI edge actions SHALL occur 3 clks after the pin edge.
REQ-014 SCLK edges SHALL be ignored while synchronized SS_n is high.
REQ-015 On the SS_n fall, the block SHALL clear the 5-bit bit counter, the 16-bit rx shift register and the 8-bit tx register.
REQ-016 On each SCLK rise, the block SHALL shift rx <= {rx[14:0],MOSI} and increment the bit counter, saturating at 17.
REQ-017 On the SCLK rise that makes the count 8, if the command bit7 = 1 (read), tx SHALL load reg[addr], where addr = command[6:0].
REQ-018 On SCLK falls while the count is >= 9, tx SHALL shift left and fill with 0; MISO SHALL equal tx[7] at all times.
REQ-019 The read map SHALL be: 0x0D/0x10/0x11/0x14 return the cfg registers; 0x0F returns WHOAMI; 0x22/0x23 return ptch_rt low/high; 0x2C/0x2D return AZ low/high; all other addresses return 0x00.
REQ-020 On the SS_n rise with count == 16 and rx[15] == 0, the block SHALL write rx[7:0] to the cfg register at rx[14:8] if it is writable; writes to any other address SHALL be ignored.
REQ-021 A frame ending with a count other than 16 SHALL be aborted: no write, no INT or lock side effects.
REQ-022 On smpl_vld with lock = 0, the block SHALL latch ptch_rt_in and AZ_in into the holding registers and set INT if cfg_int1[1] = 1.
REQ-023 A completed 16-bit read of 0x22 SHALL clear INT and set lock; a completed 16-bit read of 0x2D SHALL clear lock.
REQ-024 If smpl_vld arrives while lock = 1, the sample SHALL be dropped, overrun SHALL be set, and INT SHALL be unchanged.
REQ-025 If smpl_vld (accepted) coincides with an INT-clearing read completion, the set SHALL win and INT SHALL equal 1.
REQ-026 Clearing cfg_int1[1] SHALL force INT to 0 on the clk after the write; overrun SHALL clear only on reset.

Reset
REQ-027 On rst, all cfg and holding registers, tx, rx, the bit counter, lock, overrun and INT SHALL reset to 0; the SS_n and SCLK synchronizer flops SHALL reset to 1 and the MOSI synchronizer flops to 0; MISO SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL discard that frame; the next transaction SHALL require a fresh SS_n fall.

Verification
REQ-029 The bench SHALL cover: frames 0x0D02, 0x1053, 0x1150, 0x1460 -> cfg_int1 = 0x02, cfg_xl = 0x53, cfg_g = 0x50, cfg_ctrl5 = 0x60.
REQ-030 The bench SHALL cover: cfg_int1 = 0x02, smpl_vld with ptch_rt_in = 16'h1234 and AZ_in = 16'hFE01 -> INT = 1; reads A200, A300, AC00, AD00 -> MISO bytes 0x34, 0x12, 0x01, 0xFE; INT = 0 after the first read.
REQ-031 The bench SHALL cover: smpl_vld between the 0x22 read and the 0x2D read -> sample dropped, overrun = 1, and the subsequent 0x2C/0x2D reads return the old sample.
REQ-032 The bench SHALL cover: read 0x8F00 -> returns 0x6A; read 0xB000 -> returns 0x00.
REQ-033 The bench SHALL cover: SS_n raised after 12 SCLKs of frame 0x1077 -> cfg_xl unchanged; a frame with 17 SCLKs -> ignored.
REQ-034 The bench SHALL cover: rst asserted mid-frame -> all outputs 0, and the next full frame 0x0D02 is accepted correctly.
